sa_tile_sequencer: RTL and testbench

- Sequences one systolic-array tile at a time through four phases: operand feed, accumulator flush, context switch, and output-scan drain.
- Drives the array's global pipeline enable, the per-column context-switch vector and the scan enable.
- Collects the per-row scan-chain outputs into a valid/ready stream.
- Sits between the core configuration/control logic, the operand feeders, and the output write-back path.

---
 rtl/sa_tile_sequencer.sv | 175 +++++++++++++++++
 tb/tb_sa_tile_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_tile_sequencer.sv
// Tile sequencer for a systolic array: steps each tile through operand feed,
// accumulator flush (with staggered per-column context switches) and an
// output-scan drain that is presented as a valid/ready stream.
module sa_tile_sequencer #(
    parameter int unsigned X      = 3,
    parameter int unsigned Y      = 3,
    parameter int unsigned OC_W   = 48,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned CS_DLY = 2,
    localparam int unsigned COL_W = (X > 1) ? $clog2(X) : 1
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                i_start,
    input  logic [CNT_W-1:0]    i_k_len,
    input  logic [CNT_W-1:0]    i_n_tiles,
    input  logic                i_feed_valid,
    output logic                o_feed_en,
    output logic                o_pipeline_en,
    output logic [X-1:0]        o_cswitch_arr,
    output logic                o_cscan_en,
    input  logic [Y*OC_W-1:0]   i_c_arr,
    output logic                o_out_valid,
    output logic [Y*OC_W-1:0]   o_out_data,
    output logic [COL_W-1:0]    o_out_col,
    input  logic                i_out_ready,
    output logic                o_busy,
    output logic                o_done
);

    // Flush lasts until the last column has switched context and the
    // last row's partial sums have reached the scan chain.
    localparam int unsigned FLUSH_LEN = CS_DLY + X + Y - 2;
    localparam int unsigned F_W       = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StFeed  = 3'd1;
    localparam logic [2:0] StFlush = 3'd2;
    localparam logic [2:0] StDrain = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] k_q, k_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic [CNT_W-1:0] tile_q, tile_d;
    logic [F_W-1:0]   flush_q, flush_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [CNT_W:0]   tile_inc;

    // One extra bit so that tile+1 never wraps when N is at its maximum.
    assign tile_inc = {1'b0, tile_q} + {{CNT_W{1'b0}}, 1'b1};

    // Outputs decoded from the current state and the handshake inputs.
    always_comb begin
        o_feed_en     = 1'b0;
        o_pipeline_en = 1'b0;
        o_cswitch_arr = '0;
        o_cscan_en    = 1'b0;
        o_out_valid   = 1'b0;
        o_out_data    = '0;
        o_out_col     = '0;
        o_busy        = (state_q != StIdle);
        o_done        = (state_q == StDone);
        case (state_q)
            StFeed: begin
                o_feed_en     = i_feed_valid;
                o_pipeline_en = i_feed_valid;
            end
            StFlush: begin
                o_pipeline_en = 1'b1;
                for (int i = 0; i < int'(X); i++) begin
                    if (flush_q == F_W'(CS_DLY - 1 + i)) begin
                        o_cswitch_arr[i] = 1'b1;
                    end
                end
            end
            StDrain: begin
                o_pipeline_en = i_out_ready;
                o_cscan_en    = 1'b1;
                o_out_valid   = 1'b1;
                o_out_data    = i_c_arr;
                o_out_col     = col_q;
            end
            default: ;
        endcase
    end

    // Next-state logic; everything past IDLE only moves on pipeline advance.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        n_d     = n_q;
        beat_d  = beat_q;
        tile_d  = tile_q;
        flush_d = flush_q;
        col_d   = col_q;
        case (state_q)
            StIdle: begin
                if (i_start) begin
                    k_d    = i_k_len;
                    n_d    = i_n_tiles;
                    beat_d = '0;
                    tile_d = '0;
                    if (i_k_len == '0 || i_n_tiles == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StFeed;
                    end
                end
            end
            StFeed: begin
                if (o_feed_en) begin
                    if (beat_q == k_q - CNT_W'(1)) begin
                        flush_d = '0;
                        state_d = StFlush;
                    end else begin
                        beat_d = beat_q + CNT_W'(1);
                    end
                end
            end
            StFlush: begin
                if (flush_q == F_W'(FLUSH_LEN - 1)) begin
                    col_d   = '0;
                    state_d = StDrain;
                end else begin
                    flush_d = flush_q + F_W'(1);
                end
            end
            StDrain: begin
                if (i_out_ready) begin
                    if (col_q == COL_W'(X - 1)) begin
                        if (tile_inc < {1'b0, n_q}) begin
                            tile_d  = tile_inc[CNT_W-1:0];
                            beat_d  = '0;
                            state_d = StFeed;
                        end else begin
                            state_d = StDone;
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and counter registers; reset discards any job in flight.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= StIdle;
            k_q     <= '0;
            n_q     <= '0;
            beat_q  <= '0;
            tile_q  <= '0;
            flush_q <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            n_q     <= n_d;
            beat_q  <= beat_d;
            tile_q  <= tile_d;
            flush_q <= flush_d;
            col_q   <= col_d;
        end
    end

endmodule

// File: tb/tb_sa_tile_sequencer.sv
// Scoreboard bench for sa_tile_sequencer: stimulus queues the expected feed
// beats, context switches, output beats and done pulses with their cycle
// numbers; a negedge monitor pops and compares whenever the DUT shows one.
module tb_sa_tile_sequencer;

    localparam int X      = 3;
    localparam int Y      = 3;
    localparam int OC_W   = 48;
    localparam int CNT_W  = 16;
    localparam int CS_DLY = 2;
    localparam int DW     = Y * OC_W;
    localparam int COL_W  = 2;

    logic             i_clk = 1'b0;
    logic             i_rstn;
    logic             i_start;
    logic [CNT_W-1:0] i_k_len;
    logic [CNT_W-1:0] i_n_tiles;
    logic             i_feed_valid;
    logic             o_feed_en;
    logic             o_pipeline_en;
    logic [X-1:0]     o_cswitch_arr;
    logic             o_cscan_en;
    logic [DW-1:0]    i_c_arr = '0;
    logic             o_out_valid;
    logic [DW-1:0]    o_out_data;
    logic [COL_W-1:0] o_out_col;
    logic             i_out_ready;
    logic             o_busy;
    logic             o_done;

    sa_tile_sequencer #(
        .X(X), .Y(Y), .OC_W(OC_W), .CNT_W(CNT_W), .CS_DLY(CS_DLY)
    ) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_k_len(i_k_len),
        .i_n_tiles(i_n_tiles), .i_feed_valid(i_feed_valid), .o_feed_en(o_feed_en),
        .o_pipeline_en(o_pipeline_en), .o_cswitch_arr(o_cswitch_arr),
        .o_cscan_en(o_cscan_en), .i_c_arr(i_c_arr), .o_out_valid(o_out_valid),
        .o_out_data(o_out_data), .o_out_col(o_out_col), .i_out_ready(i_out_ready),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {int cyc; int col; logic [DW-1:0] data;} beat_t;
    typedef struct {int cyc; logic [X-1:0] v;} cs_t;

    beat_t exp_beats[$];
    cs_t   exp_cs[$];
    int    exp_feed[$];
    int    exp_done[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int busy_cnt = 0, done_cnt = 0, idle_cnt = 0, stall_cnt = 0, beat_cnt = 0;
    int t0;
    int b0, d0, i0, s0, n0;

    function automatic logic [DW-1:0] mk(input int t);
        logic [DW-1:0] r;
        for (int l = 0; l < Y; l++) r[l*OC_W +: OC_W] = OC_W'((t << 4) + l + 1);
        return r;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        total++;
        bad++;
        $display("FAIL %s: event at cycle %0d but none expected", name, cyc);
    endtask

    // Array model: scan-chain contents advance only when the array is not frozen.
    always @(posedge i_clk) begin
        cyc <= cyc + 1;
        if (i_out_ready) i_c_arr <= mk(cyc + 1);
    end

    // Monitor / scoreboard.
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic [COL_W-1:0] prev_col;
    always @(negedge i_clk) begin
        int    e;
        cs_t   c;
        beat_t b;
        if (o_feed_en) begin
            if (exp_feed.size() == 0) unexpected("feed_en");
            else begin
                e = exp_feed.pop_front();
                check("feed_cycle", cyc, e);
            end
        end
        if (o_cswitch_arr != '0) begin
            if (exp_cs.size() == 0) unexpected("cswitch");
            else begin
                c = exp_cs.pop_front();
                check("cswitch_cycle", cyc, c.cyc);
                check("cswitch_value", o_cswitch_arr, c.v);
            end
        end
        if (o_out_valid && i_out_ready) begin
            beat_cnt <= beat_cnt + 1;
            if (exp_beats.size() == 0) unexpected("out_beat");
            else begin
                b = exp_beats.pop_front();
                check("beat_cycle", cyc, b.cyc);
                check("beat_col", o_out_col, b.col);
                check("beat_data", o_out_data, b.data);
            end
        end
        if (o_out_valid && !i_out_ready) begin
            stall_cnt <= stall_cnt + 1;
            check("stall_pipe_en", o_pipeline_en, 1'b0);
            check("stall_cscan_en", o_cscan_en, 1'b1);
            if (prev_stall) begin
                check("stall_data_stable", o_out_data, prev_data);
                check("stall_col_stable", o_out_col, prev_col);
            end
        end
        prev_stall <= o_out_valid && !i_out_ready;
        prev_data  <= o_out_data;
        prev_col   <= o_out_col;
        if (o_done) begin
            done_cnt <= done_cnt + 1;
            if (exp_done.size() == 0) unexpected("done");
            else begin
                e = exp_done.pop_front();
                check("done_cycle", cyc, e);
            end
        end
        if (o_busy) busy_cnt <= busy_cnt + 1;
        if (o_busy && !o_done && !o_pipeline_en) idle_cnt <= idle_cnt + 1;
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic go(input int k, input int n);
        i_k_len   = CNT_W'(k);
        i_n_tiles = CNT_W'(n);
        i_start   = 1'b1;
        step();
        i_start   = 1'b0;
    endtask

    task automatic snap();
        b0 = busy_cnt; d0 = done_cnt; i0 = idle_cnt; s0 = stall_cnt; n0 = beat_cnt;
    endtask

    task automatic check_drained(input string name);
        check(name, exp_feed.size() + exp_cs.size() + exp_beats.size() + exp_done.size(), 0);
    endtask

    // Standard single-tile K=4 timeline, offset by `sh` cycles after the feed.
    task automatic push_tile4(input int base, input int sh);
        for (int i = 0; i < X; i++) exp_cs.push_back('{base + 6 + sh + i, X'(1 << i)});
        for (int c = 0; c < X; c++)
            exp_beats.push_back('{base + 11 + sh + c, c, mk(base + 11 + sh + c)});
        exp_done.push_back(base + 14 + sh);
    endtask

    initial begin
        i_rstn = 1'b0; i_start = 1'b0; i_k_len = '0; i_n_tiles = '0;
        i_feed_valid = 1'b1; i_out_ready = 1'b1;
        step(); step();
        check("reset_outputs", {o_feed_en, o_pipeline_en, o_cswitch_arr, o_cscan_en,
              o_out_valid, o_out_data, o_out_col, o_busy, o_done}, '0);
        i_rstn = 1'b1;
        step(); step();
        check("idle_outputs", {o_feed_en, o_pipeline_en, o_cswitch_arr, o_cscan_en,
              o_out_valid, o_out_data, o_out_col, o_busy, o_done}, '0);

        // 1: K=4 N=1, no back-pressure.
        t0 = cyc; snap();
        for (int i = 1; i <= 4; i++) exp_feed.push_back(t0 + i);
        push_tile4(t0, 0);
        go(4, 1);
        run_to(t0 + 17);
        check("t1_busy_cycles", busy_cnt - b0, 14);
        check("t1_done_count", done_cnt - d0, 1);
        check("t1_idle_cycles", idle_cnt - i0, 0);
        check_drained("t1_queues_empty");

        // 2: feeder starves in cycles 2-3, whole timeline slips by 2.
        t0 = cyc; snap();
        exp_feed.push_back(t0 + 1);
        for (int i = 4; i <= 6; i++) exp_feed.push_back(t0 + i);
        push_tile4(t0, 2);
        go(4, 1);
        step(); i_feed_valid = 1'b0;
        step(); step(); i_feed_valid = 1'b1;
        run_to(t0 + 19);
        check("t2_busy_cycles", busy_cnt - b0, 16);
        check("t2_idle_cycles", idle_cnt - i0, 2);
        check_drained("t2_queues_empty");

        // 3: ready low for 3 cycles while column 1 is presented.
        t0 = cyc; snap();
        for (int i = 1; i <= 4; i++) exp_feed.push_back(t0 + i);
        for (int i = 0; i < X; i++) exp_cs.push_back('{t0 + 6 + i, X'(1 << i)});
        exp_beats.push_back('{t0 + 11, 0, mk(t0 + 11)});
        exp_beats.push_back('{t0 + 15, 1, mk(t0 + 12)});
        exp_beats.push_back('{t0 + 16, 2, mk(t0 + 16)});
        exp_done.push_back(t0 + 17);
        go(4, 1);
        run_to(t0 + 12); i_out_ready = 1'b0;
        run_to(t0 + 15); i_out_ready = 1'b1;
        run_to(t0 + 20);
        check("t3_stall_cycles", stall_cnt - s0, 3);
        check("t3_idle_cycles", idle_cnt - i0, 3);
        check_drained("t3_queues_empty");

        // 4: K=2 N=3, 11 cycles per tile back to back.
        t0 = cyc; snap();
        for (int t = 0; t < 3; t++) begin
            exp_feed.push_back(t0 + 11 * t + 1);
            exp_feed.push_back(t0 + 11 * t + 2);
            for (int i = 0; i < X; i++) exp_cs.push_back('{t0 + 11 * t + 4 + i, X'(1 << i)});
            for (int c = 0; c < X; c++)
                exp_beats.push_back('{t0 + 11 * t + 9 + c, c, mk(t0 + 11 * t + 9 + c)});
        end
        exp_done.push_back(t0 + 34);
        go(2, 3);
        run_to(t0 + 37);
        check("t4_beats", beat_cnt - n0, 9);
        check("t4_done_count", done_cnt - d0, 1);
        check_drained("t4_queues_empty");

        // 5: degenerate jobs go straight from IDLE to DONE.
        t0 = cyc; snap();
        exp_done.push_back(t0 + 1);
        go(0, 5);
        run_to(t0 + 4);
        t0 = cyc;
        exp_done.push_back(t0 + 1);
        go(3, 0);
        run_to(t0 + 4);
        check("t5_busy_cycles", busy_cnt - b0, 2);
        check("t5_beats", beat_cnt - n0, 0);
        check_drained("t5_queues_empty");

        // 6: stray start while busy, then reset in the middle of FLUSH.
        t0 = cyc;
        for (int i = 1; i <= 4; i++) exp_feed.push_back(t0 + i);
        exp_cs.push_back('{t0 + 6, X'(1)});
        go(4, 1);
        run_to(t0 + 3);
        i_k_len = 16'd9; i_n_tiles = 16'd7; i_start = 1'b1;
        step(); i_start = 1'b0;
        run_to(t0 + 7);
        i_rstn = 1'b0;
        #1;
        check("async_reset_outputs", {o_feed_en, o_pipeline_en, o_cswitch_arr, o_cscan_en,
              o_out_valid, o_out_data, o_out_col, o_busy, o_done}, '0);
        step(); step();
        i_rstn = 1'b1;
        step(); step(); step();
        check("post_reset_idle", o_busy, 1'b0);
        check_drained("t6_queues_empty");

        t0 = cyc; snap();
        exp_feed.push_back(t0 + 1);
        for (int i = 0; i < X; i++) exp_cs.push_back('{t0 + 3 + i, X'(1 << i)});
        for (int c = 0; c < X; c++) exp_beats.push_back('{t0 + 8 + c, c, mk(t0 + 8 + c)});
        exp_done.push_back(t0 + 11);
        go(1, 1);
        run_to(t0 + 14);
        check("t6_new_job_done", done_cnt - d0, 1);
        check_drained("t6_new_job_queues_empty");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
